// File: rtl/snake_cmd_exec.sv
// snake_cmd_exec
//   Executes snake-core draw commands against the 32x24 tile map. Commands
//   land in a small FIFO (the upstream cannot be stalled). Each command is
//   expanded into one tile-memory write per cell, in raster order.
//
//   Command layout (bit positions assume the default field widths):
//     POINT op=0 : x=[27:23] y=[22:18] colour=[17:10]
//     RECT  op=1 : x0=[27:23] y0=[22:18] x1=[17:13] y1=[12:8] colour=[7:0]
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   cmd         32-bit command word
//   cmd_vld     command valid, one per cycle, no ready
//   tile_we     registered tile-memory write strobe
//   tile_addr   registered {y, x}
//   tile_wdata  registered colour id
//   busy        FIFO non-empty or FSM not idle
//   drop_pulse  one-cycle pulse when a command is discarded
//   drop_cnt    (SNAKE_CMD_EXEC_STATS_EN) saturating count of drop_pulse cycles
//   drop_clr    (SNAKE_CMD_EXEC_STATS_EN) synchronous clear of drop_cnt
//
// Build option: define SNAKE_CMD_EXEC_STATS_EN to add drop_cnt/drop_clr.
//
// state  | meaning
// S_IDLE | nothing in progress, waiting for the FIFO to fill
// S_POP  | head word popped, decoded, range-checked and latched
// S_FILL | one cell written per cycle until (xe, ye)

module snake_cmd_exec #(
   parameter int                         H_LOGIC_WIDTH  = 5,
   parameter int                         V_LOGIC_WIDTH  = 5,
   parameter logic [H_LOGIC_WIDTH-1:0]   H_LOGIC_MAX    = 5'd31,
   parameter logic [V_LOGIC_WIDTH-1:0]   V_LOGIC_MAX    = 5'd23,
   parameter int                         COLOR_ID_WIDTH = 8,
   parameter int                         FIFO_AW        = 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [31:0]                            cmd,
   input  logic                                   cmd_vld,
   output logic                                   tile_we,
   output logic [V_LOGIC_WIDTH+H_LOGIC_WIDTH-1:0] tile_addr,
   output logic [COLOR_ID_WIDTH-1:0]              tile_wdata,
   output logic                                   busy,
   output logic                                   drop_pulse
`ifdef SNAKE_CMD_EXEC_STATS_EN
   ,
   input  logic                                   drop_clr,
   output logic [15:0]                            drop_cnt
`endif
);

   localparam int H = H_LOGIC_WIDTH;
   localparam int V = V_LOGIC_WIDTH;
   localparam int C = COLOR_ID_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_POP, S_FILL} state_t;

   state_t state, state_nxt;

   // ---------------- command FIFO ----------------
   logic [31:0]      fifo_mem [2**FIFO_AW];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic             fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic             ovf_drop;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   // A simultaneous pop frees the slot, so a push into a full FIFO is accepted.
   assign fifo_push  = cmd_vld && (!fifo_full || fifo_pop);
   assign ovf_drop   = cmd_vld && !fifo_push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= cmd;
   end

   // ---------------- head decode ----------------
   logic [31:0]  head;
   logic [3:0]   h_op;
   logic         h_point, h_rect, h_range_ok;
   logic [H-1:0] hx0, hx1, hxs, hxe;
   logic [V-1:0] hy0, hy1, hys, hye;
   logic [C-1:0] hcol;

   always_comb begin
      head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];
      h_op       = head[31:28];
      h_point    = (h_op == 4'h0);
      h_rect     = (h_op == 4'h1);
      hx0        = head[27 -: H];
      hy0        = head[22 -: V];
      // A point is a rectangle whose corners coincide.
      hx1        = h_point ? hx0 : head[17 -: H];
      hy1        = h_point ? hy0 : head[12 -: V];
      hcol       = h_point ? head[17 -: C] : head[C-1:0];
      hxs        = (hx0 < hx1) ? hx0 : hx1;
      hxe        = (hx0 < hx1) ? hx1 : hx0;
      hys        = (hy0 < hy1) ? hy0 : hy1;
      hye        = (hy0 < hy1) ? hy1 : hy0;
      h_range_ok = (hxe <= H_LOGIC_MAX) && (hye <= V_LOGIC_MAX);
   end

   // ---------------- FSM ----------------
   logic [H-1:0] xs, xe, cx;
   logic [V-1:0] ye, cy;
   logic [C-1:0] colour;
   logic         load, step, cmd_bad, last_cell;

   assign last_cell = (cx == xe) && (cy == ye);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      cmd_bad   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) state_nxt = S_POP;
         end
         S_POP: begin
            fifo_pop = 1'b1;
            if (!(h_point || h_rect) || !h_range_ok) begin
               cmd_bad   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               load      = 1'b1;
               state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            step = 1'b1;
            if (last_cell) state_nxt = fifo_empty ? S_IDLE : S_POP;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- cell walker and registered write port ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xs         <= '0;
         xe         <= '0;
         ye         <= '0;
         cx         <= '0;
         cy         <= '0;
         colour     <= '0;
         tile_we    <= 1'b0;
         tile_addr  <= '0;
         tile_wdata <= '0;
      end else begin
         tile_we <= step;
         if (load) begin
            xs     <= hxs;
            xe     <= hxe;
            ye     <= hye;
            cx     <= hxs;
            cy     <= hys;
            colour <= hcol;
         end else if (step) begin
            tile_addr  <= {cy, cx};
            tile_wdata <= colour;
            if (cx == xe) begin
               cx <= xs;
               cy <= cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end

   assign busy       = !fifo_empty || (state != S_IDLE);
   assign drop_pulse = ovf_drop || cmd_bad;

`ifdef SNAKE_CMD_EXEC_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    drop_cnt <= '0;
      else if (drop_clr)                             drop_cnt <= '0;
      else if (drop_pulse && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
   end
`else
   // Drop statistics not built; drop_pulse remains the only drop indication.
`endif

endmodule

// File: tb/tb_snake_cmd_exec.sv
module tb_snake_cmd_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cmd;
   logic        cmd_vld;
   logic        tile_we;
   logic [9:0]  tile_addr;
   logic [7:0]  tile_wdata;
   logic        busy;
   logic        drop_pulse;
`ifdef SNAKE_CMD_EXEC_STATS_EN
   logic        drop_clr;
   logic [15:0] drop_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_drop  = 0;
   logic [9:0] wq_addr [$];
   logic [7:0] wq_data [$];

   snake_cmd_exec dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd),
      .cmd_vld    (cmd_vld),
      .tile_we    (tile_we),
      .tile_addr  (tile_addr),
      .tile_wdata (tile_wdata),
      .busy       (busy),
      .drop_pulse (drop_pulse)
`ifdef SNAKE_CMD_EXEC_STATS_EN
      ,
      .drop_clr   (drop_clr),
      .drop_cnt   (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tile_we === 1'b1) begin
         wq_addr.push_back(tile_addr);
         wq_data.push_back(tile_wdata);
      end
      if (drop_pulse === 1'b1) n_drop++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] w);
      @(posedge clk); #1;
      cmd     = w;
      cmd_vld = 1'b1;
      @(posedge clk); #1;
      cmd_vld = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < max) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'b0, busy}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_log();
      wq_addr.delete();
      wq_data.delete();
      n_drop = 0;
   endtask

   localparam logic [31:0] PT_3_4   = {4'h0, 5'd3, 5'd4, 8'h0f, 10'b0};
   localparam logic [31:0] FULL_SCR = {4'h1, 5'd0, 5'd0, 5'd31, 5'd23, 8'hff};
   localparam logic [31:0] RECT_REV = {4'h1, 5'd5, 5'd1, 5'd2, 5'd1, 8'h3c};
   localparam logic [31:0] BAD_OP   = {4'h7, 28'h0};
   localparam logic [31:0] PT_OOR   = {4'h0, 5'd31, 5'd24, 8'h11, 10'b0};

   initial begin
      int bad_a, bad_d;
      rst_n   = 1'b0;
      cmd     = '0;
      cmd_vld = 1'b0;
`ifdef SNAKE_CMD_EXEC_STATS_EN
      drop_clr = 1'b0;
`endif

      // reset state
      repeat (2) @(negedge clk);
      check("rst_tile_we",    {31'b0, tile_we}, 32'd0);
      check("rst_busy",       {31'b0, busy}, 32'd0);
      check("rst_drop",       {31'b0, drop_pulse}, 32'd0);
      check("rst_tile_addr",  {22'b0, tile_addr}, 32'd0);
      check("rst_tile_wdata", {24'b0, tile_wdata}, 32'd0);
`ifdef SNAKE_CMD_EXEC_STATS_EN
      check("rst_drop_cnt",   {16'b0, drop_cnt}, 32'd0);
`endif
      rst_n = 1'b1;
      clear_log();

      // 1: single point, write three cycles after the FIFO write
      send(PT_3_4);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("pt_no_early_we", {31'b0, tile_we}, 32'd0);
      end
      @(negedge clk);
      check("pt_we",    {31'b0, tile_we}, 32'd1);
      check("pt_addr",  {22'b0, tile_addr}, 32'd131);
      check("pt_wdata", {24'b0, tile_wdata}, 32'h0f);
      @(negedge clk);
      check("pt_we_end", {31'b0, tile_we}, 32'd0);
      check("pt_busy",   {31'b0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("pt_nwrites", wq_addr.size(), 32'd1);

      // 2: full-screen fill in raster order
      clear_log();
      send(FULL_SCR);
      wait_idle(1000);
      check("full_nwrites", wq_addr.size(), 32'd768);
      bad_a = 0;
      bad_d = 0;
      for (int i = 0; i < wq_addr.size(); i++) begin
         if (wq_addr[i] !== 10'(i)) bad_a++;
         if (wq_data[i] !== 8'hff)  bad_d++;
      end
      check("full_addr_order", bad_a, 32'd0);
      check("full_wdata",      bad_d, 32'd0);

      // 3: reversed x corners are normalised
      clear_log();
      send(RECT_REV);
      wait_idle(100);
      check("rev_nwrites", wq_addr.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < wq_addr.size()) begin
            check("rev_addr",  {22'b0, wq_addr[i]}, 32'd34 + 32'(i));
            check("rev_wdata", {24'b0, wq_data[i]}, 32'h3c);
         end
      end

      // 4: ten back-to-back full-screen commands overflow the FIFO
      clear_log();
      @(posedge clk); #1;
      cmd     = FULL_SCR;
      cmd_vld = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         check("burst_drop_cycle", {31'b0, drop_pulse}, (i >= 6) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end
      cmd_vld = 1'b0;
      wait_idle(5000);
      check("burst_ndrop",    n_drop, 32'd5);
      check("burst_nwrites",  wq_addr.size(), 32'd3840);

      // 5: bad opcode then out-of-range point
`ifdef SNAKE_CMD_EXEC_STATS_EN
      @(posedge clk); #1;
      drop_clr = 1'b1;
      @(posedge clk); #1;
      drop_clr = 1'b0;
`endif
      clear_log();
      send(BAD_OP);
      send(PT_OOR);
      wait_idle(100);
      check("bad_ndrop",   n_drop, 32'd2);
      check("bad_nwrites", wq_addr.size(), 32'd0);
`ifdef SNAKE_CMD_EXEC_STATS_EN
      check("bad_drop_cnt", {16'b0, drop_cnt}, 32'd2);
`endif

      // 6: asynchronous reset mid-fill
      send(FULL_SCR);
      repeat (20) @(posedge clk);
      #3;
      check("midrst_we_before", {31'b0, tile_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_we_async", {31'b0, tile_we}, 32'd0);
      check("midrst_busy",     {31'b0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      repeat (5) @(negedge clk);
      check("midrst_no_writes", wq_addr.size(), 32'd0);
      check("midrst_busy_after", {31'b0, busy}, 32'd0);
      send(PT_3_4);
      wait_idle(100);
      check("midrst_pt_nwrites", wq_addr.size(), 32'd1);
      if (wq_addr.size() > 0) begin
         check("midrst_pt_addr",  {22'b0, wq_addr[0]}, 32'd131);
         check("midrst_pt_wdata", {24'b0, wq_data[0]}, 32'h0f);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
